fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage for the single-cycle RISC-V core, sitting directly upstream of the `control` decoder and datapath. It owns the program counter and fetches instruction words over a req/ack instruction-memory port. It presents one instruction at a time, together with its PC and PC+4, to decode. When the datapath retires that instruction, it computes the next PC from the `PCsrc` and `reg_jump` decisions, with an immediate or ALU target.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `PCsrc`  in  1: from `control`; 1 = take branch/jump target. Sampled only at retire.
- `reg_jump`  in  1: from `control`; 1 = JALR (register-relative target).
- `ImmExt`  in  32: sign-extended immediate of the current instruction.
- `ALUResult`  in  32: JALR target, rs1 + imm.
- `imem_req`  out  1: fetch request; held high until ack.
- `imem_addr`  out  32: fetch address, equal to the current PC, stable while `imem_req`=1.
- `imem_ack`  in  1: read data valid this cycle; ignored when `imem_req`=0.
- `imem_rdata`  in  32: instruction word, valid with `imem_ack`.
- `Instr`  out  32: held instruction word to `control`/datapath.
- `PC`  out  32: address of `Instr`.
- `PCPlus4`  out  32: PC + 4, used as the JAL/JALR link value.
- `instr_valid`  out  1: `Instr`/`PC` are valid.
- `instr_ready`  in  1: datapath retires the instruction this cycle.
- `fetch_err`  out  1: sticky misaligned-target error.
- `retire_cnt`  out  32: count of retired instructions; wraps modulo 2^32.

## Operation
- FSM states: BOOT, FETCH, VALID, ERROR.
- **BOOT**
  - `imem_req`=0, `instr_valid`=0.
  - Goes unconditionally to FETCH next cycle.
- **FETCH**
  - `imem_req`=1, `imem_addr`=PC.
  - On `imem_ack`: capture `imem_rdata` into `Instr` and go to VALID.
  - Otherwise stay in FETCH.
- **VALID**
  - `instr_valid`=1; `Instr`, `PC` and `PCPlus4` are held stable.
  - On `instr_ready` (retire), compute the next PC:
    - `PCsrc`=0: PC+4.
    - `PCsrc`=1, `reg_jump`=0: PC+`ImmExt`.
    - `PCsrc`=1, `reg_jump`=1: {`ALUResult`[31:1], 1'b0}.
  - Retire with next PC[1:0]==0:
    - PC ← next PC.
    - `retire_cnt` += 1.
    - Go to FETCH.
  - Retire with next PC[1:0]!=0:
    - `retire_cnt` += 1.
    - PC is unchanged.
    - Go to ERROR.
- **ERROR**
  - `fetch_err`=1, `imem_req`=0, `instr_valid`=0.
  - Stays in ERROR until `rst`.
- Arithmetic:
  - All PC arithmetic is 32-bit unsigned modulo 2^32; 0xFFFF_FFFC + 4 = 0x0000_0000.
  - `ImmExt` is added as two's complement; no overflow detection.
- `PCPlus4` is derived combinationally from the PC register.
- `Instr` keeps its last value outside VALID; it is only meaningful while `instr_valid`=1.

## Timing
- **Reset.** `rst` sampled high gives, next cycle:
  - state=BOOT, PC=`RESET_PC`, `Instr`=32'h0000_0013 (NOP).
  - `instr_valid`=0, `imem_req`=0, `fetch_err`=0, `retire_cnt`=0.
  - Reset overrides every other event in the same cycle, including ack, retire and error.
- **First request.** `imem_req` first rises in the second cycle after `rst` falls (BOOT lasts one cycle).
- **Fetch latency.** `imem_ack` in cycle N gives `instr_valid`=1 in cycle N+1. A same-cycle ack means two cycles per instruction minimum.
- **Retire.** `instr_ready` in cycle M (while VALID) gives:
  - cycle M+1: `instr_valid`=0, new PC on `imem_addr`, `imem_req`=1.
  - `PCsrc`, `reg_jump`, `ImmExt` and `ALUResult` are sampled in cycle M only.
- `instr_ready` while not VALID is ignored.
- `imem_ack` outside FETCH is ignored; a stale ack arriving during BOOT or ERROR must not load `Instr`.
- **Reset mid-fetch.** `rst` while FETCH is waiting drops `imem_req` the next cycle. The outstanding request is abandoned; the memory must not ack it once req is low.
- **Reset in VALID.** `rst` in VALID together with `instr_ready` performs no retire and no count increment.

## Test plan
- **Reset and sequential fetch.**
  - Stimulus: `RESET_PC`=0; memory acks the same cycle it sees `imem_req`; `instr_ready` held at 1; 4 instructions with `PCsrc`=0.
  - Required response:
    - `imem_addr` sequence 0x0, 0x4, 0x8, 0xC.
    - `instr_valid` pulses every 2nd cycle.
    - `retire_cnt`=4.
- **Wait states and backpressure.**
  - Stimulus: ack delayed 3 cycles; `instr_ready` delayed 2 cycles.
  - Required response:
    - `imem_addr` stable throughout the wait.
    - `Instr`/`PC` stable while valid and not ready.
    - No double count.
- **Branch and JAL.**
  - At PC=0x10 retire with `PCsrc`=1, `reg_jump`=0, `ImmExt`=0xFFFF_FFF8: next fetch at 0x08.
  - With `ImmExt`=0x100: next fetch at 0x110.
  - `PCPlus4` reads 0x14 while PC=0x10.
- **JALR.**
  - Retire with `reg_jump`=1, `ALUResult`=0x0000_0203: next fetch at 0x202.
  - Retire with `ALUResult`=0x0000_0206: `fetch_err`=1, `imem_req`=0 from then on, `retire_cnt` incremented once.
  - `rst` afterwards clears `fetch_err`.
- **Wrap-around.** PC=0xFFFF_FFFC retired with `PCsrc`=0: next fetch at 0x0000_0000, no error.
- **Reset mid-operation and stale ack.**
  - Stimulus: assert `rst` while in FETCH with ack pending; drive `imem_ack`=1 during BOOT.
  - Required response:
    - `Instr` remains 0x0000_0013.
    - `imem_req`=0 during BOOT.
    - The first fetch after reset is at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage: owns the PC, fetches over a req/ack
//            port, holds one instruction for decode, computes the next PC.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCsrc,
    input  logic        reg_jump,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_err,
    output logic [31:0] retire_cnt
);

    localparam logic [31:0] c_nop = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic        imem_req_q, imem_req_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] w_next_pc;

    // JALR clears bit 0 of the ALU target; masking keeps every input bit in use.
    always_comb begin
        w_next_pc = pc_q + 32'd4;
        if (PCsrc) begin
            if (reg_jump) begin
                w_next_pc = ALUResult & 32'hFFFF_FFFE;
            end else begin
                w_next_pc = pc_q + ImmExt;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        retire_cnt_d  = retire_cnt_q;
        imem_req_d    = imem_req_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;
        case (state_q)
            ST_BOOT: begin
                state_d    = ST_FETCH;
                imem_req_d = 1'b1;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    state_d       = ST_VALID;
                    imem_req_d    = 1'b0;
                    instr_valid_d = 1'b1;
                end
            end
            ST_VALID: begin
                if (instr_ready) begin
                    retire_cnt_d  = retire_cnt_q + 32'd1;
                    instr_valid_d = 1'b0;
                    if (w_next_pc[1:0] == 2'b00) begin
                        pc_d       = w_next_pc;
                        state_d    = ST_FETCH;
                        imem_req_d = 1'b1;
                    end else begin
                        state_d     = ST_ERROR;
                        fetch_err_d = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
                fetch_err_d   = 1'b1;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            instr_q       <= c_nop;
            retire_cnt_q  <= 32'd0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            retire_cnt_q  <= retire_cnt_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign Instr       = instr_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_q + 32'd4;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;
    assign retire_cnt  = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed plus randomized checks of fetch_unit against a
//            transaction-level PC/count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        PCsrc;
    logic        reg_jump;
    logic [31:0] ImmExt;
    logic [31:0] ALUResult;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;
    logic [31:0] retire_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: architectural PC, retired count, error flag, held word.
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_err;
    logic [31:0] m_instr;

    fetch_unit #(.RESET_PC(C_RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .PCsrc      (PCsrc),
        .reg_jump   (reg_jump),
        .ImmExt     (ImmExt),
        .ALUResult  (ALUResult),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .Instr      (Instr),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .fetch_err  (fetch_err),
        .retire_cnt (retire_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input bit stale_ack);
        rst         = 1'b1;
        instr_ready = 1'($urandom % 2);
        imem_ack    = 1'b0;
        step();
        rst         = 1'b0;
        instr_ready = 1'b0;
        m_pc        = C_RESET_PC;
        m_cnt       = 32'd0;
        m_err       = 1'b0;
        m_instr     = C_NOP;
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_err",   {31'd0, fetch_err},   32'd0);
        chk("rst_cnt",   retire_cnt,           32'd0);
        chk("rst_instr", Instr,                C_NOP);
        chk("rst_pc",    PC,                   C_RESET_PC);
        imem_ack   = stale_ack;
        imem_rdata = $urandom;
        step();
        imem_ack = 1'b0;
        chk("first_req",   {31'd0, imem_req}, 32'd1);
        chk("first_addr",  imem_addr,         C_RESET_PC);
        chk("stale_instr", Instr,             C_NOP);
    endtask

    task automatic error_hold();
        for (int i = 0; i < 3; i++) begin
            imem_ack    = 1'b1;
            imem_rdata  = $urandom;
            instr_ready = 1'($urandom % 2);
            step();
            chk("err_sticky", {31'd0, fetch_err},   32'd1);
            chk("err_req",    {31'd0, imem_req},    32'd0);
            chk("err_valid",  {31'd0, instr_valid}, 32'd0);
            chk("err_instr",  Instr,                m_instr);
            chk("err_cnt",    retire_cnt,           m_cnt);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
    endtask

    task automatic run_instr(input int ack_dly, input int rdy_dly, input bit src,
                             input bit rj, input logic [31:0] imm,
                             input logic [31:0] alu, input bit rst_retire);
        logic [31:0] word;
        logic [31:0] nxt;
        word = $urandom;
        for (int i = 0; i < 8 && imem_req !== 1'b1; i++) step();
        chk("req_up",    {31'd0, imem_req}, 32'd1);
        chk("fetch_adr", imem_addr,         m_pc);
        for (int i = 0; i < ack_dly; i++) begin
            instr_ready = 1'($urandom % 2);
            step();
            chk("addr_stable", imem_addr,         m_pc);
            chk("req_held",    {31'd0, imem_req}, 32'd1);
            chk("wait_cnt",    retire_cnt,        m_cnt);
        end
        instr_ready = 1'b0;
        imem_ack    = 1'b1;
        imem_rdata  = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        m_instr    = word;
        chk("valid_up", {31'd0, instr_valid}, 32'd1);
        chk("instr",    Instr,                word);
        chk("pc",       PC,                   m_pc);
        chk("pcplus4",  PCPlus4,              m_pc + 32'd4);
        chk("req_down", {31'd0, imem_req},    32'd0);
        for (int i = 0; i < rdy_dly; i++) begin
            step();
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_instr", Instr,                word);
            chk("hold_pc",    PC,                   m_pc);
            chk("hold_cnt",   retire_cnt,           m_cnt);
        end
        instr_ready = 1'b1;
        PCsrc       = src;
        reg_jump    = rj;
        ImmExt      = imm;
        ALUResult   = alu;
        rst         = rst_retire;
        step();
        instr_ready = 1'b0;
        rst         = 1'b0;
        PCsrc       = 1'($urandom % 2);
        reg_jump    = 1'($urandom % 2);
        ImmExt      = $urandom;
        ALUResult   = $urandom;
        if (rst_retire) begin
            m_pc    = C_RESET_PC;
            m_cnt   = 32'd0;
            m_err   = 1'b0;
            m_instr = C_NOP;
            chk("rstv_cnt",   retire_cnt,           32'd0);
            chk("rstv_pc",    PC,                   C_RESET_PC);
            chk("rstv_valid", {31'd0, instr_valid}, 32'd0);
            chk("rstv_instr", Instr,                C_NOP);
            return;
        end
        if (!src)      nxt = m_pc + 32'd4;
        else if (!rj)  nxt = m_pc + imm;
        else           nxt = (alu / 2) * 2;
        m_cnt = m_cnt + 32'd1;
        chk("ret_cnt",   retire_cnt,           m_cnt);
        chk("ret_valid", {31'd0, instr_valid}, 32'd0);
        if (nxt % 4 != 0) begin
            m_err = 1'b1;
            chk("ret_err",  {31'd0, fetch_err}, 32'd1);
            chk("ret_noreq", {31'd0, imem_req}, 32'd0);
            chk("ret_pckeep", PC,               m_pc);
        end else begin
            m_pc = nxt;
            chk("ret_req",   {31'd0, imem_req},  32'd1);
            chk("ret_addr",  imem_addr,          nxt);
            chk("ret_noerr", {31'd0, fetch_err}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] imm;
        logic [31:0] alu;
        rst         = 1'b1;
        PCsrc       = 1'b0;
        reg_jump    = 1'b0;
        ImmExt      = 32'd0;
        ALUResult   = 32'd0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        m_pc = C_RESET_PC; m_cnt = 0; m_err = 0; m_instr = C_NOP;
        step();
        do_reset(1'b0);

        // Sequential fetch 0x0..0xC, zero wait states.
        for (int i = 0; i < 4; i++) run_instr(0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("seq_cnt4", retire_cnt, 32'd4);
        chk("seq_pc10", imem_addr,  32'h10);

        // Backward branch with wait states and backpressure: 0x10 -> 0x08.
        run_instr(3, 2, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0, 1'b0);
        run_instr(0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        run_instr(1, 1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        run_instr(0, 0, 1'b1, 1'b0, 32'h100, 32'd0, 1'b0);
        chk("jal_110", imem_addr, 32'h110);

        // JALR, then wrap-around at the top of the address space.
        run_instr(2, 0, 1'b1, 1'b1, 32'd0, 32'h0000_0205, 1'b0);
        run_instr(0, 0, 1'b1, 1'b1, 32'd0, 32'hFFFF_FFFD, 1'b0);
        run_instr(0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("wrap_zero", imem_addr, 32'h0);

        // Misaligned JALR target: sticky error, cleared only by reset.
        run_instr(0, 0, 1'b1, 1'b1, 32'd0, 32'h0000_0206, 1'b0);
        error_hold();
        do_reset(1'b1);

        // Reset while a fetch is outstanding, with a stale ack in BOOT.
        imem_ack = 1'b0;
        step();
        do_reset(1'b1);

        // Reset coinciding with a retire.
        run_instr(0, 1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        run_instr(0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            imm = 32'(($urandom_range(0, 63) - 32) * 4);
            if ($urandom_range(0, 7) == 0) imm = imm + 32'($urandom_range(1, 3));
            alu = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) alu = alu | 32'($urandom_range(1, 3));
            else alu = alu | 32'($urandom_range(0, 1));
            run_instr($urandom_range(0, 3), $urandom_range(0, 2),
                      1'($urandom % 2), 1'($urandom % 2), imm, alu,
                      ($urandom_range(0, 19) == 0));
            if (m_err) begin
                error_hold();
                do_reset(1'($urandom % 2));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
